trap_ctrl: RTL

Machine-mode trap sequencer for the pipelined RV32I core. Sits beside the EX stage: takes the decoder's `invalid_instruction` flag plus ecall/ebreak/mret decode bits carried down the pipeline, and arbitrates them against pending interrupts. Runs a fixed multi-cycle sequence that kills the offending instruction, flushes the pipe, commits trap CSR state, and redirects the PC to `mtvec` (trap) or `mepc` (mret).

---
 rtl/trap_ctrl_pkg.sv | 22 ++
 rtl/trap_ctrl_irq_arbiter.sv | 35 +++
 rtl/trap_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Holds the state encoding, mcause codes and mtvec mode values.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_JUMP   = 2'd3
  } trap_state_e;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CAUSE_BREAK   = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL_M = 32'h0000_000B;
  localparam logic [31:0] CAUSE_MSI     = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_ctrl_irq_arbiter.sv
// Fixed-priority machine interrupt arbiter: external > software > timer.
// A source is eligible only when its line, its enable and global MIE are set.
module irq_arbiter
  import trap_ctrl_pkg::*;
(
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        mie_meie,
  input  logic        mie_msie,
  input  logic        mie_mtie,
  input  logic        mstatus_mie,
  output logic        irq_take,
  output logic [31:0] irq_cause
);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    irq_take  = 1'b0;
    irq_cause = '0;
    if (mstatus_mie) begin
      if (irq_ext && mie_meie) begin
        irq_take  = 1'b1;
        irq_cause = CAUSE_MEI;
      end else if (irq_sw && mie_msie) begin
        irq_take  = 1'b1;
        irq_cause = CAUSE_MSI;
      end else if (irq_timer && mie_mtie) begin
        irq_take  = 1'b1;
        irq_cause = CAUSE_MTI;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: kills the EX instruction, flushes for three
// cycles, commits trap CSR state and redirects the PC to mtvec or mepc.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_invalid,
  input  logic            ex_ecall,
  input  logic            ex_ebreak,
  input  logic            ex_mret,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            mstatus_mie,
  input  logic            mie_meie,
  input  logic            mie_msie,
  input  logic            mie_mtie,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  output logic            ex_kill,
  output logic            flush,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            csr_trap_we,
  output logic [XLEN-1:0] csr_mepc,
  output logic [XLEN-1:0] csr_mcause,
  output logic            csr_mret,
  output logic            busy
);

  trap_state_e     state, state_nxt;
  logic            irq_take;
  logic [31:0]     irq_cause;
  logic            ev_take, ev_irq, ev_mret;
  logic [XLEN-1:0] ev_cause;
  logic [XLEN-1:0] lat_pc, lat_cause;
  logic            lat_irq, lat_mret;
  logic [XLEN-1:0] tvec_base;

  irq_arbiter u_irq_arbiter (
    .irq_ext     (irq_ext),
    .irq_sw      (irq_sw),
    .irq_timer   (irq_timer),
    .mie_meie    (mie_meie),
    .mie_msie    (mie_msie),
    .mie_mtie    (mie_mtie),
    .mstatus_mie (mstatus_mie),
    .irq_take    (irq_take),
    .irq_cause   (irq_cause)
  );

  // Exceptions outrank interrupts; mret is taken only when nothing else is.
  always_comb begin
    ev_take  = 1'b1;
    ev_irq   = 1'b0;
    ev_mret  = 1'b0;
    ev_cause = '0;
    if (ex_invalid)      ev_cause = CAUSE_ILLEGAL;
    else if (ex_ebreak)  ev_cause = CAUSE_BREAK;
    else if (ex_ecall)   ev_cause = CAUSE_ECALL_M;
    else if (irq_take) begin
      ev_cause = irq_cause;
      ev_irq   = 1'b1;
    end else if (ex_mret) ev_mret = 1'b1;
    else                  ev_take = 1'b0;
  end

  assign ex_kill = (state == ST_IDLE) && ex_valid && ev_take;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (ex_kill) state_nxt = ST_FLUSH;
      ST_FLUSH:  state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_JUMP;
      ST_JUMP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge, and state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_pc    <= '0;
      lat_cause <= '0;
      lat_irq   <= 1'b0;
      lat_mret  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ex_kill) begin
        lat_pc    <= ex_pc;
        lat_cause <= ev_cause;
        lat_irq   <= ev_irq;
        lat_mret  <= ev_mret;
      end
    end
  end

  assign tvec_base = {mtvec_in[XLEN-1:2], 2'b00};

  always_comb begin
    busy           = (state != ST_IDLE);
    flush          = (state != ST_IDLE);
    stall          = (state == ST_FLUSH) || (state == ST_COMMIT);
    redirect_valid = (state == ST_JUMP);
    csr_trap_we    = (state == ST_COMMIT) && !lat_mret;
    csr_mret       = (state == ST_COMMIT) && lat_mret;
    csr_mepc       = lat_pc;
    csr_mcause     = lat_cause;
    redirect_pc    = '0;
    // Vectored offset is 4 x code with the interrupt bit shifted out.
    if (state == ST_JUMP) begin
      if (lat_mret)
        redirect_pc = mepc_in;
      else if (lat_irq && (mtvec_in[1:0] == MTVEC_VECTORED))
        redirect_pc = tvec_base + {lat_cause[XLEN-3:0], 2'b00};
      else
        redirect_pc = tvec_base;
    end
  end

endmodule
